// File: rtl/peripheral_pkg.sv
// Shared definitions for the memory-mapped peripheral window: register offsets,
// timer control bit positions and the default base address (also used by CPU decode).
package peripheral_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;
  localparam logic [31:0] WINDOW_BYTES      = 32'd32;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SWITCH  = 5'h10;
  localparam logic [4:0] OFF_DIGI    = 5'h14;
  localparam logic [4:0] OFF_SYSTICK = 5'h18;
  localparam logic [4:0] OFF_RSVD    = 5'h1C;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    SEL_TH      = 3'd0,
    SEL_TL      = 3'd1,
    SEL_TCON    = 3'd2,
    SEL_LED     = 3'd3,
    SEL_SWITCH  = 3'd4,
    SEL_DIGI    = 3'd5,
    SEL_SYSTICK = 3'd6,
    SEL_RSVD    = 3'd7
  } reg_sel_e;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off < WINDOW_BYTES;
  endfunction

endpackage

// File: rtl/peripheral_timer.sv
// Reloadable up-counter: TL counts while enabled, reloads from TH on all-ones and
// latches a sticky interrupt status bit when interrupts are enabled.
module peripheral_timer
  import peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic overflow;

  assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign irq      = tcon[TCON_IS];

  // Software writes take priority over the hardware update; the reload reads the
  // pre-edge TH so a TH write in the overflow cycle only affects the next reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th)
        th <= wdata;

      if (wr_tl)
        tl <= wdata;
      else if (overflow)
        tl <= th;
      else if (tcon[TCON_EN])
        tl <= tl + 32'd1;

      if (wr_tcon)
        tcon <= wdata[2:0];
      else if (overflow && tcon[TCON_IE])
        tcon[TCON_IS] <= 1'b1;
    end
  end

endmodule

// File: rtl/peripheral.sv
// Memory-mapped peripheral on the MEM stage: timer, LEDs, seven-segment digits,
// synchronised switches and a free-running cycle counter, with zero-latency reads.
module peripheral
  import peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
  parameter int          SW_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        irq,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  logic [31:0] offset;
  reg_sel_e    sel;
  logic        wr_en;
  logic [31:0] th, tl, systick, rdata;
  logic [2:0]  tcon;
  logic [7:0]  sw_sync [SW_SYNC_STAGES];

  assign offset = Address - BASE_ADDR;
  assign hit    = in_window(Address, BASE_ADDR);
  assign sel    = reg_sel_e'(offset[4:2]);
  assign wr_en  = MemWrite && hit;

  peripheral_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr_en && (sel == SEL_TH)),
    .wr_tl   (wr_en && (sel == SEL_TL)),
    .wr_tcon (wr_en && (sel == SEL_TCON)),
    .wdata   (Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      digi    <= '0;
      systick <= '0;
      for (int i = 0; i < SW_SYNC_STAGES; i++)
        sw_sync[i] <= '0;
    end else begin
      systick    <= systick + 32'd1;
      sw_sync[0] <= switch;
      for (int i = 1; i < SW_SYNC_STAGES; i++)
        sw_sync[i] <= sw_sync[i-1];
      if (wr_en && (sel == SEL_LED))
        led <= Write_data[7:0];
      if (wr_en && (sel == SEL_DIGI))
        digi <= Write_data[11:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_TH:      rdata = th;
      SEL_TL:      rdata = tl;
      SEL_TCON:    rdata = {29'd0, tcon};
      SEL_LED:     rdata = {24'd0, led};
      SEL_SWITCH:  rdata = {24'd0, sw_sync[SW_SYNC_STAGES-1]};
      SEL_DIGI:    rdata = {20'd0, digi};
      SEL_SYSTICK: rdata = systick;
      default:     rdata = '0;
    endcase
  end

  // Registers are sampled before the edge, so a combined read+write returns the old value.
  assign Read_data = (MemRead && hit) ? rdata : 32'd0;

endmodule

// File: tb/tb_peripheral.sv
// Directed bench for the peripheral: expected read data is queued as each access is
// driven and compared when the combinational read path settles.
module tb_peripheral;
  import peripheral_pkg::*;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite, hit, irq;
  logic [7:0]  switch, led;
  logic [11:0] digi;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  peripheral #(.BASE_ADDR(B), .SW_SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .hit        (hit),
    .irq        (irq),
    .switch     (switch),
    .led        (led),
    .digi       (digi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, obs, e);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    push_exp(exp, tag);
    Address  = addr;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    pop_cmp(Read_data);
    MemRead  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    Address    = addr;
    Write_data = data;
    MemWrite   = 1'b1;
    MemRead    = 1'b0;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Address = '0; Write_data = '0;
    MemRead = 1'b0; MemWrite = 1'b0; switch = 8'h00;
    idle(3);

    rd(B + OFF_TH,      32'd0, "rst_th");
    rd(B + OFF_TL,      32'd0, "rst_tl");
    rd(B + OFF_TCON,    32'd0, "rst_tcon");
    rd(B + OFF_SYSTICK, 32'd0, "rst_systick");
    chk("rst_irq",  {31'd0, irq}, 32'd0);
    chk("rst_led",  {24'd0, led}, 32'd0);
    chk("rst_digi", {20'd0, digi}, 32'd0);

    reset = 1'b0;
    idle(2);
    rd(B + OFF_SWITCH,  32'd0, "sw_after_reset");
    rd(B + OFF_DIGI,    32'd0, "digi_after_reset");
    rd(B + OFF_SYSTICK, 32'd2, "systick_2");
    wr(B + OFF_SYSTICK, 32'h0);
    rd(B + OFF_SYSTICK, 32'd3, "systick_ro");
    wr(B + OFF_SWITCH, 32'hFF);
    rd(B + OFF_SWITCH,  32'd0, "switch_ro");

    wr(B + OFF_LED, 32'h1234_56C3);
    rd(B + OFF_LED, 32'h0000_00C3, "led_zext");
    chk("led_port", {24'd0, led}, 32'hC3);
    rd(B + OFF_LED + 32'd1, 32'h0000_00C3, "led_byte_ofs");
    wr(B + OFF_DIGI, 32'hFFFF_FABC);
    rd(B + OFF_DIGI, 32'h0000_0ABC, "digi_zext");
    chk("digi_port", {20'd0, digi}, 32'hABC);
    wr(B + OFF_RSVD, 32'hDEAD_BEEF);
    rd(B + OFF_RSVD, 32'd0, "rsvd_zero");

    Address = B + OFF_LED; MemRead = 1'b0; #1;
    chk("hit_in_window", {31'd0, hit}, 32'd1);
    chk("rd_not_reading", Read_data, 32'd0);
    rd(B + 32'h20, 32'd0, "rd_above_window");
    chk("hit_above", {31'd0, hit}, 32'd0);
    Address = 32'h0000_0010; Write_data = 32'hFF; MemWrite = 1'b1; #1;
    chk("hit_low_addr", {31'd0, hit}, 32'd0);
    @(negedge clk); MemWrite = 1'b0;
    chk("led_unhit_write", {24'd0, led}, 32'hC3);

    push_exp(32'hC3, "rw_prewrite");
    Address = B + OFF_LED; Write_data = 32'h11; MemRead = 1'b1; MemWrite = 1'b1; #1;
    pop_cmp(Read_data);
    @(negedge clk); MemRead = 1'b0; MemWrite = 1'b0;
    rd(B + OFF_LED, 32'h11, "rw_postwrite");

    switch = 8'hA5;
    idle(1);
    rd(B + OFF_SWITCH, 32'h00, "sw_sync_1");
    idle(1);
    rd(B + OFF_SWITCH, 32'hA5, "sw_sync_2");

    wr(B + OFF_TH,   32'hFFFF_FFF0);
    wr(B + OFF_TL,   32'hFFFF_FFFE);
    wr(B + OFF_TCON, 32'd3);
    rd(B + OFF_TL, 32'hFFFF_FFFE, "tl_start");
    idle(1);
    rd(B + OFF_TL, 32'hFFFF_FFFF, "tl_plus1");
    chk("irq_pre_ovf", {31'd0, irq}, 32'd0);
    idle(1);
    rd(B + OFF_TL, 32'hFFFF_FFF0, "tl_reload");
    chk("irq_ovf", {31'd0, irq}, 32'd1);
    rd(B + OFF_TCON, 32'd7, "tcon_ovf");

    wr(B + OFF_TCON, 32'd3);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd(B + OFF_TL, 32'hFFFF_FFF1, "tl_after_clr");
    idle(1);
    rd(B + OFF_TL, 32'hFFFF_FFF2, "tl_continue");

    wr(B + OFF_TL, 32'hFFFF_FFFE);
    idle(1);
    wr(B + OFF_TL, 32'd5);
    rd(B + OFF_TL, 32'd5, "tl_sw_wins");
    rd(B + OFF_TH, 32'hFFFF_FFF0, "th_untouched");
    idle(1);
    rd(B + OFF_TL, 32'd6, "tl_after_sw");

    wr(B + OFF_TL, 32'hFFFF_FFFE);
    idle(1);
    wr(B + OFF_TH, 32'h100);
    rd(B + OFF_TL, 32'hFFFF_FFF0, "reload_old_th");
    rd(B + OFF_TH, 32'h100, "th_new");

    wr(B + OFF_TCON, 32'd3);
    wr(B + OFF_TL, 32'hFFFF_FFFE);
    idle(1);
    wr(B + OFF_TCON, 32'd3);
    chk("irq_sw_tcon_wins", {31'd0, irq}, 32'd0);
    rd(B + OFF_TCON, 32'd3, "tcon_sw_wins");
    rd(B + OFF_TL, 32'h100, "reload_new_th");

    wr(B + OFF_TCON, 32'd0);
    rd(B + OFF_TL, 32'h101, "tl_last_count");
    idle(3);
    rd(B + OFF_TL, 32'h101, "tl_frozen");
    wr(B + OFF_TCON, 32'd4);
    chk("irq_when_disabled", {31'd0, irq}, 32'd1);
    rd(B + OFF_TL, 32'h101, "tl_still_frozen");

    wr(B + OFF_TCON, 32'd7);
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    chk("irq_async_rst", {31'd0, irq}, 32'd0);
    rd(B + OFF_TL,  32'd0, "tl_async_rst");
    rd(B + OFF_LED, 32'd0, "led_async_rst");
    idle(1);
    reset = 1'b0;
    idle(1);
    rd(B + OFF_TL, 32'd0, "tl_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
